// File: rtl/obi_apb_bridge.sv
// OBI-to-APB4 bridge: one OBI transaction at a time, run as an APB SETUP/ACCESS
// transfer, with a ready watchdog and a saturating error counter on the sideband.
package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_apb_bridge
  import obi_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 256,
  parameter logic [31:0] ErrRdata      = 32'hBADCAB1E,
  parameter int unsigned CntWidth      = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  obi_req_t            obi_req_i,
  output obi_resp_t           obi_resp_o,
  output logic [31:0]         paddr_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [31:0]         pwdata_o,
  output logic [3:0]          pstrb_o,
  output logic [2:0]          pprot_o,
  input  logic [31:0]         prdata_i,
  input  logic                pready_i,
  input  logic                pslverr_i,
  output logic                err_o,
  output logic [CntWidth-1:0] err_cnt_o,
  input  logic                err_cnt_clr_i
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // The counter only needs to reach TimeoutCycles-1.
  localparam int unsigned TW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam int unsigned TmoLastInt = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;
  localparam logic [TW-1:0] TmoLast = TW'(TmoLastInt);

  logic [1:0]          state_q, state_d;
  logic                we_q, we_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                gnt;

  assign gnt = obi_req_i.req & ((state_q == IDLE) | (state_q == RESP)) & ~rst_i;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE, RESP: begin
        if (gnt) begin
          state_d = SETUP;
          we_d    = obi_req_i.we;
          be_d    = obi_req_i.be;
          addr_d  = obi_req_i.addr;
          wdata_d = obi_req_i.wdata;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        tmo_d   = '0;
      end
      default: begin
        // A late pready wins over the watchdog firing in the same cycle.
        if (pready_i) begin
          state_d = RESP;
          err_d   = pslverr_i;
          rdata_d = we_q ? 32'h0 : (pslverr_i ? ErrRdata : prdata_i);
        end else if ((TimeoutCycles != 0) && (tmo_q == TmoLast)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = we_q ? 32'h0 : ErrRdata;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (err_cnt_clr_i) begin
      cnt_d = '0;
    end else if ((state_q == RESP) && err_q && (cnt_q != {CntWidth{1'b1}})) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign psel_o     = (state_q == SETUP) | (state_q == ACCESS);
  assign penable_o  = (state_q == ACCESS);
  assign paddr_o    = addr_q;
  assign pwrite_o   = we_q;
  assign pwdata_o   = wdata_q;
  assign pstrb_o    = we_q ? be_q : 4'b0000;
  assign pprot_o    = 3'b000;
  assign err_o      = err_q;
  assign err_cnt_o  = cnt_q;
  assign obi_resp_o = '{gnt: gnt, rvalid: (state_q == RESP), rdata: rdata_q};

endmodule

// File: tb/tb_obi_apb_bridge.sv
// Scoreboard bench for obi_apb_bridge: stimulus pushes expected responses,
// an APB slave model answers transfers, and a monitor checks every rvalid.
module tb_obi_apb_bridge;
  import obi_pkg::*;

  localparam int          T   = 4;
  localparam logic [31:0] ERR = 32'hBADCAB1E;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  obi_req_t    req;
  obi_resp_t   resp;
  logic [31:0] paddr_o, pwdata_o, prdata_i;
  logic        psel_o, penable_o, pwrite_o, pready_i, pslverr_i, err_o;
  logic [3:0]  pstrb_o;
  logic [2:0]  pprot_o;
  logic [7:0]  err_cnt_o;
  logic        clr_man = 1'b0, clr_rnd = 1'b0, rnd_clr_en = 1'b0;
  logic        err_cnt_clr;
  assign err_cnt_clr = clr_man | clr_rnd;

  obi_apb_bridge #(.TimeoutCycles(T), .ErrRdata(ERR), .CntWidth(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .obi_req_i(req), .obi_resp_o(resp),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pprot_o(pprot_o), .prdata_i(prdata_i),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .err_o(err_o), .err_cnt_o(err_cnt_o),
    .err_cnt_clr_i(err_cnt_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic err; int cyc; } exp_t;
  typedef struct {
    logic we; logic [3:0] be; logic [31:0] addr, wdata, prdata; int waits; logic slverr;
  } apb_t;

  exp_t expq[$];
  apb_t apbq[$];
  int   errors = 0, checks = 0;
  int   last_gnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // APB slave: answers each ACCESS after the scripted number of wait states.
  initial begin
    apb_t cur;
    int   acnt;
    cur = '{default: '0};
    acnt = 0;
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0;
    forever begin
      @(negedge clk);
      #1;
      pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = $urandom;
      if (rst_i) continue;
      if (psel_o && !penable_o) begin
        if (apbq.size() == 0) fail("apb_unexpected_setup");
        else begin
          cur = apbq.pop_front();
          acnt = 0;
          chk("setup_paddr", paddr_o, cur.addr);
          chk("setup_pwrite", 32'(pwrite_o), 32'(cur.we));
          chk("setup_pwdata", pwdata_o, cur.wdata);
          chk("setup_pstrb", 32'(pstrb_o), cur.we ? 32'(cur.be) : 32'h0);
        end
      end else if (psel_o && penable_o) begin
        chk("access_paddr", paddr_o, cur.addr);
        chk("access_pwrite", 32'(pwrite_o), 32'(cur.we));
        chk("access_pstrb", 32'(pstrb_o), cur.we ? 32'(cur.be) : 32'h0);
        if (acnt == cur.waits) begin
          pready_i = 1'b1; pslverr_i = cur.slverr; prdata_i = cur.prdata;
        end
        acnt++;
      end
    end
  end

  // Monitor: pops the scoreboard on rvalid and tracks the error counter.
  initial begin
    exp_t e;
    int   mcnt;
    logic inc;
    mcnt = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_i) begin mcnt = 0; continue; end
      chk("err_cnt", 32'(err_cnt_o), 32'(mcnt));
      inc = 1'b0;
      if (psel_o) chk("gnt_while_busy", 32'(resp.gnt), 32'h0);
      if (resp.rvalid) begin
        if (expq.size() == 0) fail("rvalid_unexpected");
        else begin
          e = expq.pop_front();
          chk("rdata", resp.rdata, e.rdata);
          chk("err_o", 32'(err_o), 32'(e.err));
          chk("rvalid_cycle", 32'(cyc), 32'(e.cyc));
          chk("psel_in_resp", 32'({psel_o, penable_o}), 32'h0);
          inc = e.err;
        end
      end
      if (err_cnt_clr) mcnt = 0;
      else if (inc && mcnt != 255) mcnt++;
    end
  end

  always @(negedge clk) clr_rnd = rnd_clr_en && ($urandom_range(0, 9) == 0);

  // Issues one request from a negedge; returns one negedge after the grant.
  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] prdata,
                       input int waits, input logic slverr);
    exp_t e;
    apb_t a;
    int   k;
    req.req = 1'b1; req.we = we; req.be = be; req.addr = addr; req.wdata = wdata;
    k = 0;
    #1;
    while (!resp.gnt && k < 50) begin @(negedge clk); #1; k++; end
    if (!resp.gnt) begin
      fail("gnt_timeout");
      req.req = 1'b0;
      return;
    end
    last_gnt = cyc;
    if (waits >= T) begin
      e.err = 1'b1;
      e.rdata = we ? 32'h0 : ERR;
    end else begin
      e.err = slverr;
      e.rdata = we ? 32'h0 : (slverr ? ERR : prdata);
    end
    e.cyc = cyc + 3 + ((waits < T) ? waits : T - 1);
    a = '{we: we, be: be, addr: addr, wdata: wdata, prdata: prdata, waits: waits, slverr: slverr};
    expq.push_back(e);
    apbq.push_back(a);
    @(negedge clk);
    req.req = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (expq.size() != 0 && k < 200) begin @(negedge clk); k++; end
    if (expq.size() != 0) begin fail("drain_timeout"); expq.delete(); apbq.delete(); end
    @(negedge clk);
  endtask

  initial begin
    int g[3];
    req = '0;
    repeat (2) @(negedge clk);
    req.req = 1'b1;
    #1;
    chk("gnt_in_reset", 32'(resp.gnt), 32'h0);
    chk("reset_ctrl", 32'({psel_o, penable_o, pwrite_o, resp.rvalid, err_o}), 32'h0);
    chk("reset_data", paddr_o | pwdata_o | resp.rdata | 32'(pstrb_o) | 32'(err_cnt_o), 32'h0);
    chk("pprot", 32'(pprot_o), 32'h0);
    req.req = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    issue(1'b0, 4'hF, 32'h1000_0000, 32'h0, 32'h1234_5678, 0, 1'b0);
    drain();
    issue(1'b1, 4'b0011, 32'h2000_0010, 32'hCAFE_F00D, 32'h5555_5555, 2, 1'b0);
    drain();
    issue(1'b0, 4'hF, 32'h3000_0004, 32'h0, 32'h7777_7777, 0, 1'b1);
    drain();
    issue(1'b0, 4'hF, 32'h3000_0008, 32'h0, 32'h1111_2222, 10, 1'b0);
    drain();
    issue(1'b0, 4'hF, 32'h3000_000C, 32'h0, 32'hABCD_0123, T - 1, 1'b0);
    drain();
    issue(1'b1, 4'hC, 32'h3000_0010, 32'hDEAD_BEEF, 32'h0, T, 1'b0);
    drain();

    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 4'hF, 32'h4000_0000 + 32'(i * 4), 32'h0, $urandom, 0, 1'b0);
      g[i] = last_gnt;
    end
    drain();
    chk("b2b_gap01", 32'(g[1] - g[0]), 32'd3);
    chk("b2b_gap12", 32'(g[2] - g[1]), 32'd3);

    rnd_clr_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      issue($urandom_range(0, 1), 4'($urandom), $urandom, $urandom, $urandom,
            $urandom_range(0, 6), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    rnd_clr_en = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 260; i++) issue(1'b0, 4'hF, $urandom, 32'h0, $urandom, 0, 1'b1);
    drain();
    chk("err_cnt_saturated", 32'(err_cnt_o), 32'hFF);

    issue(1'b0, 4'hF, 32'h5000_0000, 32'h0, 32'h0, 0, 1'b1);
    begin
      int k;
      k = 0;
      @(negedge clk); #1;
      while (!resp.rvalid && k < 20) begin @(negedge clk); #1; k++; end
      if (!resp.rvalid) fail("clr_rvalid_timeout");
      clr_man = 1'b1;
      @(negedge clk);
      clr_man = 1'b0;
      #3;
      chk("clr_priority", 32'(err_cnt_o), 32'h0);
    end
    drain();

    issue(1'b0, 4'hF, 32'h6000_0000, 32'h0, 32'h0, 20, 1'b0);
    @(negedge clk);
    #1;
    chk("in_access", 32'({psel_o, penable_o}), 32'h3);
    rst_i = 1'b1;
    expq.delete();
    apbq.delete();
    @(negedge clk);
    rst_i = 1'b0;
    #3;
    chk("post_reset_apb", 32'({psel_o, penable_o, resp.rvalid}), 32'h0);
    chk("post_reset_paddr", paddr_o, 32'h0);
    repeat (6) @(negedge clk);
    issue(1'b0, 4'hF, 32'h7000_0000, 32'h0, 32'h0BAD_F00D, 1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/obi_apb_bridge.md
Name: obi_apb_bridge

Overview:
- OBI-to-APB4 bridge hanging off one slave port of the system crossbar; drives a single APB4 peripheral segment.
- Accepts one OBI transaction at a time and runs it as an APB SETUP/ACCESS transfer.
- Returns the OBI response and flags APB errors and timeouts on a sideband.
- Back-to-back accesses are supported: a new request can be granted in the response cycle.

Parameters:
- TimeoutCycles, 256: maximum ACCESS cycles waiting for pready_i before abort; 0 disables the watchdog.
- ErrRdata, 32'hBADCAB1E: rdata returned on a read that errors or times out.
- CntWidth, 8: width of the saturating error counter.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-high reset.
- obi_req_i  input  obi_pkg::obi_req_t  request from the crossbar slave port (req, we, be[3:0], addr[31:0], wdata[31:0]).
- obi_resp_o  output  obi_pkg::obi_resp_t  response to the crossbar (gnt, rvalid, rdata[31:0]).
- paddr_o  output  32  APB address.
- psel_o  output  1  APB select.
- penable_o  output  1  APB enable.
- pwrite_o  output  1  APB write.
- pwdata_o  output  32  APB write data.
- pstrb_o  output  4  APB write strobes.
- pprot_o  output  3  APB protection; tied to 3'b000.
- prdata_i  input  32  APB read data.
- pready_i  input  1  APB ready.
- pslverr_i  input  1  APB slave error.
- err_o  output  1  high together with obi_resp_o.rvalid when the transaction errored (pslverr or timeout).
- err_cnt_o  output  CntWidth  saturating count of errored transactions.
- err_cnt_clr_i  input  1  synchronous clear of err_cnt_o.

Behaviour:
- One clock (clk_i); reset is synchronous and active-high (rst_i).
- Reset:
  - state goes to IDLE.
  - psel_o, penable_o, pwrite_o, obi_resp_o.rvalid, err_o = 0.
  - paddr_o, pwdata_o, pstrb_o, obi_resp_o.rdata, err_cnt_o = 0.
  - obi_resp_o.gnt is forced to 0 while rst_i is high.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- Grant:
  - gnt is combinational: gnt = obi_req_i.req & (state==IDLE | state==RESP).
  - On gnt, latch we, be, addr, wdata into the transaction register and go to SETUP.
  - Otherwise RESP goes to IDLE.
- SETUP (one cycle):
  - psel_o=1, penable_o=0.
  - paddr_o=addr (unmodified), pwrite_o=we, pwdata_o=wdata.
  - pstrb_o = we ? be : 4'b0000.
  - Next state: ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1; all APB address/control/data outputs held stable.
  - If pready_i=1:
    - capture rdata = we ? 32'h0 : prdata_i.
    - capture err = pslverr_i; on a read with pslverr_i=1, rdata = ErrRdata.
    - go to RESP.
  - Timeout counter: cleared on entry to ACCESS, increments each ACCESS cycle with pready_i=0.
  - If TimeoutCycles!=0 and the counter reaches TimeoutCycles-1 while pready_i=0, on that edge:
    - abort the transfer: psel_o and penable_o drop next cycle.
    - err=1, rdata = we ? 0 : ErrRdata.
    - go to RESP.
  - pready_i takes precedence over timeout in the same cycle.
- RESP (one cycle):
  - obi_resp_o.rvalid=1, obi_resp_o.rdata = captured rdata, err_o = captured err.
  - psel_o=0, penable_o=0.
- Output persistence: rdata/err_o are only meaningful while rvalid=1; they hold their last value otherwise.
- Latency and throughput:
  - Grant in cycle 0, SETUP in cycle 1, ACCESS in cycle 2 (pready_i=1), rvalid in cycle 3.
  - Each pready_i wait state adds one cycle.
  - Back-to-back requests run at one transaction per 3 cycles.
- Error counter:
  - Increments by 1 in each RESP cycle with err=1; saturates at all-ones.
  - err_cnt_clr_i has priority over an increment in the same cycle (result 0).
- At most one transaction is outstanding; the OBI master never sees a second gnt before the prior rvalid cycle.
- Reset mid-transfer: the APB transfer is abandoned at the reset edge with no rvalid; the outputs take their reset values on the next cycle.

Test Plan:
- Read, pready_i=1 immediately, prdata_i=32'h1234_5678 -> gnt cycle 0; psel_o=1/penable_o=0 in cycle 1; penable_o=1 in cycle 2; rvalid=1, rdata=32'h1234_5678, err_o=0 in cycle 3.
- Write addr=32'h2000_0010, be=4'b0011, wdata=32'hCAFE_F00D, 2 wait states -> pstrb_o=4'b0011, pwrite_o=1, APB signals stable across 3 ACCESS cycles; rvalid in cycle 5 with rdata=0.
- Read with pslverr_i=1 -> rdata=32'hBADCAB1E, err_o=1, err_cnt_o 0->1; 256 such errors -> err_cnt_o stays 8'hFF.
- TimeoutCycles=4, pready_i held 0 -> 4 ACCESS cycles, psel_o drops, rvalid with err_o=1, rdata=ErrRdata; pready_i=1 on the 4th cycle instead -> normal completion.
- Request held continuously for 3 reads -> gnt in cycles 0, 3, 6; rvalid in cycles 3, 6, 9; no gnt in SETUP or ACCESS.
- rst_i asserted during ACCESS -> next cycle psel_o=penable_o=0, no rvalid; err_cnt_clr_i together with an error RESP -> err_cnt_o=0.
